// File: rtl/alu_ex_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ex_sequencer
//
// Execute-stage controller that sits directly upstream of a multicycle ALU.
// It takes one decoded ALU instruction at a time from ID/EX, holds the ALU
// operand/control inputs stable for the op-dependent number of execute cycles,
// captures the ALU result and offers it to writeback together with the
// destination register and a byte-enable mask derived from the ppp field.
//
// Ports (bit numbering is big-endian, [0] is the MSB):
//   clk                    rising-edge clock
//   rst_n                  synchronous active-low reset
//   in_valid / in_ready    ID/EX handshake (in_ready is combinational)
//   in_type, in_oprA/B,    decoded instruction fields, latched on accept
//   in_ww, in_imm, in_ppp,
//   in_rd
//   alu_en, alu_type,      ALU control/operands; alu_en high only in EXEC,
//   alu_oprA/B, alu_ww,    the rest change only on accept or reset
//   alu_imm
//   alu_dout               ALU result, sampled on the last EXEC cycle
//   out_valid / out_ready  writeback handshake
//   out_data, out_rd,      captured result, destination and byte enables,
//   out_be                 held until the writeback handshake completes
// -----------------------------------------------------------------------------
module alu_ex_sequencer #(
    parameter int MUL_LAT = 3,   // execute cycles for mul odd/even, 1..15
    parameter int W       = 64   // datapath width, only 64 supported
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:5]   in_type,
    input  logic [0:W-1] in_oprA,
    input  logic [0:W-1] in_oprB,
    input  logic [0:1]   in_ww,
    input  logic [0:4]   in_imm,
    input  logic [0:2]   in_ppp,
    input  logic [0:4]   in_rd,

    output logic         alu_en,
    output logic [0:5]   alu_type,
    output logic [0:W-1] alu_oprA,
    output logic [0:W-1] alu_oprB,
    output logic [0:1]   alu_ww,
    output logic [0:4]   alu_imm,
    input  logic [0:W-1] alu_dout,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] out_data,
    output logic [0:4]   out_rd,
    output logic [0:7]   out_be
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [0:5] OP_MUL_ODD  = 6'b000111;
    localparam logic [0:5] OP_MUL_EVEN = 6'b001000;

    // Counter holds the number of EXEC cycles still to go after the current one.
    localparam logic [3:0] MUL_CNT   = 4'(MUL_LAT - 1);
    localparam logic [3:0] SHORT_CNT = 4'd0;

    // Byte-enable mask for each participation code; codes 101..111 enable
    // nothing, so writeback sees a valid result but performs no write.
    function automatic logic [0:7] decode_ppp(input logic [0:2] ppp);
        case (ppp)
            3'b000:  decode_ppp = 8'b1111_1111;
            3'b001:  decode_ppp = 8'b1111_0000;
            3'b010:  decode_ppp = 8'b0000_1111;
            3'b011:  decode_ppp = 8'b1010_1010;
            3'b100:  decode_ppp = 8'b0101_0101;
            default: decode_ppp = 8'b0000_0000;
        endcase
    endfunction

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;

    logic [0:5]     type_q;
    logic [0:W-1]   opr_a_q;
    logic [0:W-1]   opr_b_q;
    logic [0:1]     ww_q;
    logic [0:4]     imm_q;
    logic [0:2]     ppp_q;
    logic [0:4]     rd_q;

    logic [0:W-1]   out_data_q;
    logic [0:4]     out_rd_q;
    logic [0:7]     out_be_q;

    logic           accept;
    logic           exec_last;

    assign accept    = in_valid && in_ready;
    assign exec_last = (state_q == EXEC) && (cnt_q == 4'd0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // A new instruction can be taken on the same edge that the
                // result leaves, giving back-to-back issue with no bubble.
                if (out_ready) begin
                    state_d = in_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            cnt_d = ((in_type == OP_MUL_ODD) || (in_type == OP_MUL_EVEN))
                    ? MUL_CNT : SHORT_CNT;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        alu_en    = (state_q == EXEC);
        out_valid = (state_q == DONE);
        // Held low during reset so upstream never sees a phantom accept.
        in_ready  = rst_n && ((state_q == IDLE) ||
                              ((state_q == DONE) && out_ready));
    end

    // -------------------------------------------------------------------------
    // Instruction holding registers and result capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            type_q     <= '0;
            opr_a_q    <= '0;
            opr_b_q    <= '0;
            ww_q       <= '0;
            imm_q      <= '0;
            ppp_q      <= '0;
            rd_q       <= '0;
            out_data_q <= '0;
            out_rd_q   <= '0;
            out_be_q   <= '0;
        end else begin
            if (accept) begin
                type_q  <= in_type;
                opr_a_q <= in_oprA;
                opr_b_q <= in_oprB;
                ww_q    <= in_ww;
                imm_q   <= in_imm;
                ppp_q   <= in_ppp;
                rd_q    <= in_rd;
            end
            if (exec_last) begin
                out_data_q <= alu_dout;
                out_rd_q   <= rd_q;
                out_be_q   <= decode_ppp(ppp_q);
            end
        end
    end

    assign alu_type = type_q;
    assign alu_oprA = opr_a_q;
    assign alu_oprB = opr_b_q;
    assign alu_ww   = ww_q;
    assign alu_imm  = imm_q;

    assign out_data = out_data_q;
    assign out_rd   = out_rd_q;
    assign out_be   = out_be_q;

endmodule
